// File: rtl/dmem_responder_if.sv
// Data-memory port between the MEM stage (master) and the data-memory
// responder (slave): request strobes, byte address and write data in one
// direction, read data and the pipeline stall in the other.
interface dmem_responder_if;
    logic        MemRead_2DM;
    logic        MemWrite_2DM;
    logic [31:0] data_address_2DM;
    logic [31:0] data_write_2DM;
    logic [31:0] data_read_fDM;
    logic        DM_stall;

    modport master (
        output MemRead_2DM,
        output MemWrite_2DM,
        output data_address_2DM,
        output data_write_2DM,
        input  data_read_fDM,
        input  DM_stall
    );

    modport slave (
        input  MemRead_2DM,
        input  MemWrite_2DM,
        input  data_address_2DM,
        input  data_write_2DM,
        output data_read_fDM,
        output DM_stall
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: a single-ported word array behind a posted write
// buffer. Writes are queued and drained one per cycle while the array port
// is free; reads that match a queued write are forwarded from the youngest
// matching entry in the same cycle, all other reads go through a small
// miss FSM that stalls the pipeline for READ_LATENCY+1 cycles.
module dmem_responder #(
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 2,
    parameter int WB_DEPTH     = 4
) (
    input  logic            CLK,
    input  logic            RESET,
    dmem_responder_if.slave bus
);
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LAT_W = $clog2(READ_LATENCY + 1) + 1;
    localparam int WORDS = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Miss FSM and output state
    state_t              state_q;
    logic [LAT_W-1:0]    lat_q;
    logic [ADDR_W-1:0]   miss_idx_q;
    logic [31:0]         rdata_q;
    logic [31:0]         dout_q;

    // Word array (never reset)
    logic [31:0]         mem_q [WORDS];

    // Posted write buffer
    logic [ADDR_W-1:0]   wb_idx_q  [WB_DEPTH];
    logic [31:0]         wb_data_q [WB_DEPTH];
    logic [WB_DEPTH-1:0] wb_vld_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_d;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_d;

    // Combinational decode
    logic [ADDR_W-1:0]   req_idx_s;
    logic                rd_req_s;
    logic                wr_req_s;
    logic                full_s;
    logic                enq_s;
    logic                deq_s;
    logic                match_s;
    logic [31:0]         match_data_s;
    logic [PTR_W-1:0]    pos_s;
    logic                rd_hit_s;
    logic                rd_miss_s;
    logic                stall_s;
    logic [31:0]         dout_s;
    logic                unused_addr_s;

    // Byte offset and bits above the word index are ignored, so the
    // array simply wraps.
    assign req_idx_s     = bus.data_address_2DM[ADDR_W+1:2];
    assign unused_addr_s = ^{bus.data_address_2DM[31:ADDR_W+2], bus.data_address_2DM[1:0]};

    // A simultaneous read and write is treated as a write only.
    assign rd_req_s = bus.MemRead_2DM & ~bus.MemWrite_2DM;
    assign wr_req_s = bus.MemWrite_2DM;

    // Full is judged on the registered count, before this edge's drain.
    assign full_s = (count_q == CNT_W'(WB_DEPTH));
    assign enq_s  = wr_req_s & ~full_s;
    // The array port belongs to the miss read while in WAIT.
    assign deq_s  = (state_q != S_WAIT) && (count_q != {CNT_W{1'b0}});

    // Youngest-match search: walk the FIFO from oldest to newest so the
    // last hit seen is the most recent write to that word.
    always_comb begin
        match_s      = 1'b0;
        match_data_s = 32'd0;
        pos_s        = rd_ptr_q;
        for (int i = 0; i < WB_DEPTH; i++) begin
            pos_s = rd_ptr_q + PTR_W'(i);
            if (wb_vld_q[pos_s] && (wb_idx_q[pos_s] == req_idx_s)) begin
                match_s      = 1'b1;
                match_data_s = wb_data_q[pos_s];
            end else begin
                match_data_s = match_data_s;
            end
        end
    end

    // Hit/miss classification, stall and read-data mux.
    always_comb begin
        rd_hit_s  = rd_req_s && (state_q == S_IDLE) && match_s;
        rd_miss_s = rd_req_s && (state_q == S_IDLE) && !match_s;
        stall_s   = (state_q == S_WAIT) || rd_miss_s || (wr_req_s && full_s);
        if (rd_hit_s) begin
            dout_s = match_data_s;
        end else if (state_q == S_DONE) begin
            dout_s = rdata_q;
        end else begin
            dout_s = dout_q;
        end
    end

    assign bus.DM_stall      = stall_s;
    assign bus.data_read_fDM = dout_s;

    // Write-buffer pointer and occupancy next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (enq_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (deq_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + CNT_W'(enq_s) - CNT_W'(deq_s);
    end

    // Write-buffer control state: pointers, count and entry valid bits.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            wb_vld_q <= {WB_DEPTH{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            // Enqueue and dequeue never target the same slot: that would
            // need the buffer to be both full and empty.
            if (enq_s) begin
                wb_vld_q[wr_ptr_q] <= 1'b1;
            end
            if (deq_s) begin
                wb_vld_q[rd_ptr_q] <= 1'b0;
            end
        end
    end

    // Write-buffer payload; only meaningful where the valid bit is set.
    always_ff @(posedge CLK) begin
        if (enq_s) begin
            wb_idx_q[wr_ptr_q]  <= req_idx_s;
            wb_data_q[wr_ptr_q] <= bus.data_write_2DM;
        end
    end

    // Drain the oldest buffered write into the array.
    always_ff @(posedge CLK) begin
        if (deq_s) begin
            mem_q[wb_idx_q[rd_ptr_q]] <= wb_data_q[rd_ptr_q];
        end
    end

    // Miss FSM with captured read word and held output data.
    // lat_q counts the WAIT cycles still to go including the current one,
    // so the miss stalls for the IDLE decision cycle plus READ_LATENCY
    // WAIT cycles; a zero latency skips WAIT entirely.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            lat_q      <= {LAT_W{1'b0}};
            miss_idx_q <= {ADDR_W{1'b0}};
            rdata_q    <= 32'd0;
            dout_q     <= 32'd0;
        end else begin
            dout_q <= dout_s;
            case (state_q)
                S_IDLE: begin
                    if (rd_miss_s) begin
                        miss_idx_q <= req_idx_s;
                        lat_q      <= LAT_W'(READ_LATENCY);
                        if (READ_LATENCY == 0) begin
                            rdata_q <= mem_q[req_idx_s];
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (lat_q <= LAT_W'(1)) begin
                        rdata_q <= mem_q[miss_idx_q];
                        state_q <= S_DONE;
                    end else begin
                        lat_q <= lat_q - LAT_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder. Three instances differ only in read latency
// (2, 0, 6). Expected read data comes from a program-order word map; a
// scoreboard queue holds the expectation for each issued read and a monitor
// pops it whenever a read completes (MemRead high, MemWrite low, no stall).
module tb_dmem_responder;
    localparam int NI  = 3;
    localparam int RL0 = 2;
    localparam int RL1 = 0;
    localparam int RL2 = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n  [NI];
    logic        rd_s   [NI];
    logic        wr_s   [NI];
    logic [31:0] addr_s [NI];
    logic [31:0] wdat_s [NI];
    logic [31:0] rdat_s [NI];
    logic        stall_s[NI];

    dmem_responder_if bus0();
    dmem_responder_if bus1();
    dmem_responder_if bus2();

    assign bus0.MemRead_2DM      = rd_s[0];
    assign bus0.MemWrite_2DM     = wr_s[0];
    assign bus0.data_address_2DM = addr_s[0];
    assign bus0.data_write_2DM   = wdat_s[0];
    assign rdat_s[0]             = bus0.data_read_fDM;
    assign stall_s[0]            = bus0.DM_stall;

    assign bus1.MemRead_2DM      = rd_s[1];
    assign bus1.MemWrite_2DM     = wr_s[1];
    assign bus1.data_address_2DM = addr_s[1];
    assign bus1.data_write_2DM   = wdat_s[1];
    assign rdat_s[1]             = bus1.data_read_fDM;
    assign stall_s[1]            = bus1.DM_stall;

    assign bus2.MemRead_2DM      = rd_s[2];
    assign bus2.MemWrite_2DM     = wr_s[2];
    assign bus2.data_address_2DM = addr_s[2];
    assign bus2.data_write_2DM   = wdat_s[2];
    assign rdat_s[2]             = bus2.data_read_fDM;
    assign stall_s[2]            = bus2.DM_stall;

    dmem_responder #(.ADDR_W(10), .READ_LATENCY(RL0), .WB_DEPTH(4)) u_dut_rl2 (
        .CLK(clk), .RESET(rst_n[0]), .bus(bus0));
    dmem_responder #(.ADDR_W(10), .READ_LATENCY(RL1), .WB_DEPTH(4)) u_dut_rl0 (
        .CLK(clk), .RESET(rst_n[1]), .bus(bus1));
    dmem_responder #(.ADDR_W(10), .READ_LATENCY(RL2), .WB_DEPTH(4)) u_dut_rl6 (
        .CLK(clk), .RESET(rst_n[2]), .bus(bus2));

    typedef struct {
        int          inst;
        logic [31:0] data;
        bit          chk;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mdl [int];      // program-order memory image per instance
    logic [31:0] last_rd [NI];
    int          n_chk  = 0;
    int          n_pass = 0;

    function automatic void chk_int(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endfunction

    function automatic void chk_word(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endfunction

    function automatic int key(int k, logic [31:0] a);
        return k * 1024 + int'(a[11:2]);
    endfunction

    // Scoreboard monitor: one completed read per instance per cycle at most.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < NI; k++) begin
            if (rst_n[k] && rd_s[k] && !wr_s[k] && !stall_s[k]) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL sb_underflow: inst %0d returned %h with no read expected", k, rdat_s[k]);
                end else begin
                    e = sb_q.pop_front();
                    chk_int("sb_inst", k, e.inst);
                    if (e.chk) chk_word($sformatf("rd_data_i%0d", k), rdat_s[k], e.data);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Write held until the responder stops stalling it.
    task automatic wr_op(input int k, input logic [31:0] a, input logic [31:0] d,
                         output int stalls);
        bit ok;
        ok = 1'b0;
        stalls = 0;
        rd_s[k] = 1'b0; wr_s[k] = 1'b1; addr_s[k] = a; wdat_s[k] = d;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!stall_s[k]) ok = 1'b1;
            else stalls++;
            @(posedge clk); #1;
            if (ok) break;
        end
        wr_s[k] = 1'b0;
        if (ok) mdl[key(k, a)] = d;
        else begin
            n_chk++;
            $display("FAIL wr_timeout: inst %0d addr %h still stalled after 100 cycles", k, a);
        end
    endtask

    // One-cycle write pulse, used only where acceptance is certain.
    task automatic wr_raw(input int k, input logic [31:0] a, input logic [31:0] d);
        rd_s[k] = 1'b0; wr_s[k] = 1'b1; addr_s[k] = a; wdat_s[k] = d;
        @(posedge clk); #1;
        wr_s[k] = 1'b0;
        mdl[key(k, a)] = d;
    endtask

    // Read held until the responder stops stalling; data checked by monitor.
    task automatic rd_op(input int k, input logic [31:0] a, output int stalls);
        exp_t e;
        bit   ok;
        e.inst = k;
        e.chk  = mdl.exists(key(k, a));
        e.data = e.chk ? mdl[key(k, a)] : 32'd0;
        sb_q.push_back(e);
        last_rd[k] = e.data;
        ok = 1'b0;
        stalls = 0;
        rd_s[k] = 1'b1; wr_s[k] = 1'b0; addr_s[k] = a;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!stall_s[k]) ok = 1'b1;
            else stalls++;
            @(posedge clk); #1;
            if (ok) break;
        end
        rd_s[k] = 1'b0;
        if (!ok) begin
            n_chk++;
            $display("FAIL rd_timeout: inst %0d addr %h still stalled after 100 cycles", k, a);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s;
        int op;
        logic [31:0] a;
        logic [31:0] v1;

        for (int k = 0; k < NI; k++) begin
            rst_n[k] = 1'b0; rd_s[k] = 1'b0; wr_s[k] = 1'b0;
            addr_s[k] = 32'd0; wdat_s[k] = 32'd0; last_rd[k] = 32'd0;
        end

        // Reset state
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk_word($sformatf("rst_data_i%0d", k), rdat_s[k], 32'd0);
            chk_int($sformatf("rst_stall_i%0d", k), int'(stall_s[k]), 0);
        end
        @(posedge clk); #1;
        for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;
        idle(2);

        // Write then read forwarding, latest write wins
        wr_op(0, 32'h0000_0040, 32'hDEAD_BEEF, s); chk_int("fwd_wr_stall", s, 0);
        rd_op(0, 32'h0000_0040, s);                chk_int("fwd_rd_stall", s, 0);
        wr_op(0, 32'h0000_0040, 32'h1234_5678, s); chk_int("fwd_wr2_stall", s, 0);
        rd_op(0, 32'h0000_0040, s);                chk_int("fwd_rd2_stall", s, 0);

        // Miss latency: READ_LATENCY+1 stall cycles
        wr_op(0, 32'h0000_0080, 32'hCAFE_F00D, s); idle(3);
        rd_op(0, 32'h0000_0080, s);                chk_int("miss_rl2_stall", s, RL0 + 1);
        wr_op(1, 32'h0000_0080, 32'hCAFE_F00D, s); idle(3);
        rd_op(1, 32'h0000_0080, s);                chk_int("miss_rl0_stall", s, RL1 + 1);

        // Byte offset ignored; index wraps modulo 2^ADDR_W
        wr_op(0, 32'h0000_0103, 32'hA5A5_0103, s);
        rd_op(0, 32'h0000_0100, s);                chk_int("byteoff_hit_stall", s, 0);
        wr_op(0, 32'h0000_1000, 32'h0BAD_F00D, s); idle(3);
        rd_op(0, 32'h0000_0000, s);                chk_int("wrap_miss_stall", s, RL0 + 1);

        // Read+write together: write only, output holds, no stall
        rd_s[0] = 1'b1; wr_s[0] = 1'b1; addr_s[0] = 32'h0000_0050; wdat_s[0] = 32'h5A5A_0050;
        @(negedge clk);
        chk_int("rdwr_stall", int'(stall_s[0]), 0);
        chk_word("rdwr_hold", rdat_s[0], last_rd[0]);
        @(posedge clk); #1;
        rd_s[0] = 1'b0; wr_s[0] = 1'b0;
        mdl[key(0, 32'h0000_0050)] = 32'h5A5A_0050;
        rd_op(0, 32'h0000_0050, s);                chk_int("rdwr_enq_hit_stall", s, 0);

        // Full buffer while a miss holds WAIT (latency 6): four writes fill
        // it, the fifth stalls through the last 2 WAIT cycles and DONE.
        rd_s[2] = 1'b1; addr_s[2] = 32'h0000_03F0;
        @(negedge clk); chk_int("full_miss_stall", int'(stall_s[2]), 1);
        @(posedge clk); #1; rd_s[2] = 1'b0;
        wr_raw(2, 32'h0000_0200, 32'hD000_0000);
        wr_raw(2, 32'h0000_0204, 32'hD000_0001);
        wr_raw(2, 32'h0000_0208, 32'hD000_0002);
        wr_raw(2, 32'h0000_020C, 32'hD000_0003);
        wr_op(2, 32'h0000_0208, 32'hD000_0004, s); chk_int("full_wr5_stall", s, 3);
        // Two entries for 0x208 now buffered: youngest must be returned
        rd_op(2, 32'h0000_0208, s);                chk_int("youngest_hit_stall", s, 0);
        idle(6);
        rd_op(2, 32'h0000_0200, s);                chk_int("drain0_stall", s, RL2 + 1);
        rd_op(2, 32'h0000_0204, s);                chk_int("drain1_stall", s, RL2 + 1);
        rd_op(2, 32'h0000_0208, s);                chk_int("drain2_stall", s, RL2 + 1);
        rd_op(2, 32'h0000_020C, s);                chk_int("drain3_stall", s, RL2 + 1);

        // Reset mid-WAIT with three writes buffered
        v1 = 32'h1111_0010;
        wr_op(2, 32'h0000_0010, v1, s); idle(3);
        rd_s[2] = 1'b1; addr_s[2] = 32'h0000_03F4;
        @(negedge clk); chk_int("rst_miss_stall", int'(stall_s[2]), 1);
        @(posedge clk); #1; rd_s[2] = 1'b0;
        wr_raw(2, 32'h0000_0010, 32'h2222_0010);
        wr_raw(2, 32'h0000_0014, 32'h2222_0014);
        wr_raw(2, 32'h0000_0018, 32'h2222_0018);
        rst_n[2] = 1'b0;
        #1;
        chk_word("midrst_data", rdat_s[2], 32'd0);
        chk_int("midrst_stall", int'(stall_s[2]), 0);
        mdl[key(2, 32'h0000_0010)] = v1;
        mdl.delete(key(2, 32'h0000_0014));
        mdl.delete(key(2, 32'h0000_0018));
        @(posedge clk); #1;
        rst_n[2] = 1'b1;
        idle(1);
        rd_op(2, 32'h0000_0010, s);                chk_int("postrst_miss_stall", s, RL2 + 1);

        // Randomized traffic on the latency-2 instance
        for (int i = 0; i < 300; i++) begin
            op = int'($urandom_range(0, 2));
            a  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            if (op == 0) begin
                wr_op(0, a, $urandom, s);
                chk_int("rnd_wr_stall", s, 0);
            end else if (op == 1 && mdl.exists(key(0, a))) begin
                rd_op(0, a, s);
                chk_int("rnd_rd_stall_legal", int'(s == 0 || s == RL0 + 1), 1);
            end else begin
                idle(1);
            end
        end

        idle(4);
        chk_int("sb_leftover", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
